// File: rtl/tc_ram_dma.sv
// tc_ram_dma: single-channel copy/fill engine in front of the 256x8 TC RAM.
// Idle/done: host port passes straight through; busy: engine drives the RAM port.
module tc_ram_dma #(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_data,
    input  logic       abort,
    input  logic       host_load,
    input  logic       host_save,
    input  logic [7:0] host_address,
    input  logic [7:0] host_in,
    output logic [7:0] host_out,
    output logic       ram_load,
    output logic       ram_save,
    output logic [7:0] ram_address,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] remaining
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] dp_q, dp_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rbuf_q, rbuf_d;

    logic unused_params;
    assign unused_params = (UUID != 0) || (NAME != "");

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= '0;
            dp_q    <= '0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dp_q    <= dp_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        dp_d        = dp_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        ram_load    = 1'b0;
        ram_save    = 1'b0;
        ram_address = '0;
        ram_wdata   = '0;
        host_out    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        remaining   = '0;

        // The host owns the RAM port whenever the engine is not transferring.
        if (state_q == IDLE || state_q == DONE) begin
            ram_load    = host_load;
            ram_save    = host_save;
            ram_address = host_address;
            ram_wdata   = host_in;
            host_out    = ram_rdata;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sp_d  = src;
                    dp_d  = dst;
                    cnt_d = len;
                    if (len == 8'd0)  state_d = DONE;
                    else if (mode)    state_d = FILL;
                    else              state_d = READ;
                end
            end
            READ: begin
                busy        = 1'b1;
                remaining   = cnt_q;
                ram_address = sp_q;
                ram_load    = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rbuf_d  = ram_rdata;
                    sp_d    = sp_q + 8'd1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                remaining   = cnt_q;
                ram_address = dp_q;
                ram_save    = 1'b1;
                ram_wdata   = rbuf_q;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    dp_d    = dp_q + 8'd1;
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? DONE : READ;
                end
            end
            FILL: begin
                busy        = 1'b1;
                remaining   = cnt_q;
                ram_address = dp_q;
                ram_save    = 1'b1;
                ram_wdata   = fill_data;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    dp_d  = dp_q + 8'd1;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
